// File: rtl/miner_pkg.sv
// Shared miner definitions: header/result sizes, MINE guard length and loader FSM encoding.
// Used by header_loader, hash_tx_shifter and the miner top level.
package miner_pkg;

    localparam int HDR_BYTES_DEF  = 80;
    localparam int HASH_BYTES_DEF = 32;
    localparam int MINE_GUARD_DEF = 4;

    // Header byte counter width; 7 bits covers the 80-byte header.
    localparam int HDR_CNT_W = 7;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_MINE = 2'd1,
        ST_SEND = 2'd2
    } state_t;

endpackage

// File: rtl/hash_tx_shifter.sv
// Holds the captured hash and streams it MSB byte first on a valid/ready port; done pulses on the last accept.
// Latency: byte 0 is valid on the first enabled cycle after load; a stall (ready=0) freezes data and index.
module hash_tx_shifter
    import miner_pkg::*;
#(
    parameter int HASH_BYTES = HASH_BYTES_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [HASH_BYTES*8-1:0] load_dat,
    input  logic                    en,
    output logic [7:0]              tx_dat,
    output logic                    tx_vld,
    input  logic                    tx_rdy,
    output logic                    done
);

    localparam int J_W = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1;

    logic [HASH_BYTES*8-1:0] result;
    logic [J_W-1:0]          j;
    logic                    tx_acc;
    logic                    last_byte;

    assign tx_vld    = en;
    assign tx_acc    = en & tx_rdy;
    assign last_byte = (j == J_W'(HASH_BYTES - 1));
    assign done      = tx_acc & last_byte;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result <= '0;
            j      <= '0;
        end else begin
            if (load) begin
                result <= load_dat;
            end
            if (load) begin
                j <= '0;
            end else if (tx_acc) begin
                j <= last_byte ? '0 : j + 1'b1;
            end
        end
    end

    // Byte 0 is the top byte of the result; output is forced to zero when not sending.
    always_comb begin
        tx_dat = '0;
        if (en) begin
            for (int i = 0; i < HASH_BYTES; i++) begin
                if (j == J_W'(i)) begin
                    tx_dat = result[8*(HASH_BYTES-1-i) +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/header_loader.sv
// Collects an HDR_BYTES header from the host, holds it for the miner, then returns the winning hash bytewise.
// headerValid rises on the edge accepting the last header byte; rx is throttled by state, tx honours txReady.
module header_loader
    import miner_pkg::*;
#(
    parameter int HDR_BYTES  = HDR_BYTES_DEF,
    parameter int HASH_BYTES = HASH_BYTES_DEF,
    parameter int MINE_GUARD = MINE_GUARD_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              rxData,
    input  logic                    rxValid,
    output logic                    rxReady,
    output logic [HDR_BYTES*8-1:0]  blockHeader,
    output logic                    headerValid,
    input  logic [HASH_BYTES*8-1:0] satisfactoryHash,
    output logic [7:0]              txData,
    output logic                    txValid,
    input  logic                    txReady
);

    localparam int G_W = (MINE_GUARD > 1) ? $clog2(MINE_GUARD) : 1;

    state_t                 state;
    state_t                 state_nxt;
    logic [HDR_CNT_W-1:0]   byte_cnt;
    logic [G_W-1:0]         guard_cnt;
    logic                   guard_done;
    logic [HDR_BYTES*8-1:0] hdr_q;
    logic                   rx_acc;
    logic                   last_rx;
    logic                   hash_hit;
    logic                   tx_en;
    logic                   tx_done;

    assign rx_acc   = rxValid & rxReady;
    assign last_rx  = rx_acc & (byte_cnt == HDR_CNT_W'(HDR_BYTES - 1));
    assign hash_hit = (state == ST_MINE) & guard_done & (|satisfactoryHash);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (last_rx)  state_nxt = ST_MINE;
            ST_MINE: if (hash_hit) state_nxt = ST_SEND;
            ST_SEND: if (tx_done)  state_nxt = ST_LOAD;
            default:               state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        rxReady     = 1'b0;
        headerValid = 1'b0;
        tx_en       = 1'b0;
        case (state)
            ST_LOAD: rxReady     = 1'b1;
            ST_MINE: headerValid = 1'b1;
            ST_SEND: tx_en       = 1'b1;
            default: rxReady     = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
        end else if (rx_acc) begin
            byte_cnt <= last_rx ? '0 : byte_cnt + 1'b1;
        end
    end

    // guard_done marks that MINE_GUARD full cycles have elapsed in MINE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            guard_cnt  <= '0;
            guard_done <= 1'b0;
        end else if (state != ST_MINE) begin
            guard_cnt  <= '0;
            guard_done <= 1'b0;
        end else if (guard_cnt == G_W'(MINE_GUARD - 1)) begin
            guard_done <= 1'b1;
        end else begin
            guard_cnt <= guard_cnt + 1'b1;
        end
    end

    // First accepted byte lands in the most significant byte of the header.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hdr_q <= '0;
        end else if (rx_acc) begin
            for (int b = 0; b < HDR_BYTES; b++) begin
                if (byte_cnt == HDR_CNT_W'(b)) begin
                    hdr_q[8*(HDR_BYTES-1-b) +: 8] <= rxData;
                end
            end
        end
    end

    assign blockHeader = hdr_q;

    hash_tx_shifter #(
        .HASH_BYTES (HASH_BYTES)
    ) u_tx (
        .clock    (clock),
        .reset    (reset),
        .load     (hash_hit),
        .load_dat (satisfactoryHash),
        .en       (tx_en),
        .tx_dat   (txData),
        .tx_vld   (txValid),
        .tx_rdy   (txReady),
        .done     (tx_done)
    );

endmodule
